// File: rtl/mem_arb_if.sv
// Bundle of requester-side (IFU, LSU) and memory-side handshake signals for mem_arb.
// slave: arbiter view; master: the requesters and memory that surround it.
interface mem_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  i_ifu_req_valid;
  logic                  o_ifu_req_ready;
  logic [ADDR_WIDTH-1:0] i_ifu_req_addr;
  logic                  o_ifu_rsp_valid;
  logic [DATA_WIDTH-1:0] o_ifu_rsp_data;

  logic                  i_lsu_req_valid;
  logic                  o_lsu_req_ready;
  logic                  i_lsu_req_wr_en;
  logic [ADDR_WIDTH-1:0] i_lsu_req_addr;
  logic [DATA_WIDTH-1:0] i_lsu_req_wr_data;
  logic [MASK_WIDTH-1:0] i_lsu_req_wr_mask;
  logic                  o_lsu_rsp_valid;
  logic [DATA_WIDTH-1:0] o_lsu_rsp_data;

  logic                  o_mem_req_valid;
  logic                  i_mem_req_ready;
  logic                  o_mem_req_wr_en;
  logic [ADDR_WIDTH-1:0] o_mem_req_addr;
  logic [DATA_WIDTH-1:0] o_mem_req_wr_data;
  logic [MASK_WIDTH-1:0] o_mem_req_wr_mask;
  logic                  i_mem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_mem_rsp_data;

  modport slave (
    input  i_ifu_req_valid, i_ifu_req_addr,
    output o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rsp_data,
    input  i_lsu_req_valid, i_lsu_req_wr_en, i_lsu_req_addr, i_lsu_req_wr_data, i_lsu_req_wr_mask,
    output o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data,
    output o_mem_req_valid, o_mem_req_wr_en, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_mask,
    input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data
  );

  modport master (
    output i_ifu_req_valid, i_ifu_req_addr,
    input  o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rsp_data,
    output i_lsu_req_valid, i_lsu_req_wr_en, i_lsu_req_addr, i_lsu_req_wr_data, i_lsu_req_wr_mask,
    input  o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data,
    input  o_mem_req_valid, o_mem_req_wr_en, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_mask,
    output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between IFU fetches and LSU loads/stores, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module mem_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic     i_sys_clk,
  input  logic     i_sys_rst,
  mem_arb_if.slave bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [MASK_WIDTH-1:0] wr_mask_q, wr_mask_d;
  logic                  ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic                  lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_WIDTH-1:0] ifu_rsp_data_q, ifu_rsp_data_d;
  logic [DATA_WIDTH-1:0] lsu_rsp_data_q, lsu_rsp_data_d;
`ifdef MEM_ARB_RR_EN
  owner_e                last_q, last_d;
`endif

  logic grant_ifu;
  logic grant_lsu;
  logic idle;

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
`ifdef MEM_ARB_RR_EN
    // On contention the requester that was not granted last time wins.
    if (bus.i_lsu_req_valid && (!bus.i_ifu_req_valid || last_q == OWN_IFU)) begin
      grant_lsu = 1'b1;
    end else if (bus.i_ifu_req_valid) begin
      grant_ifu = 1'b1;
    end
`else
    if (bus.i_lsu_req_valid) begin
      grant_lsu = 1'b1;
    end else if (bus.i_ifu_req_valid) begin
      grant_ifu = 1'b1;
    end
`endif
  end

  // Ready is combinational so the accept happens in the same IDLE cycle; held low during reset.
  assign idle = (state_q == ST_IDLE) && !i_sys_rst;

  assign bus.o_ifu_req_ready = idle && grant_ifu;
  assign bus.o_lsu_req_ready = idle && grant_lsu;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    mem_req_valid_d = mem_req_valid_q;
    wr_en_d         = wr_en_q;
    addr_d          = addr_q;
    wr_data_d       = wr_data_q;
    wr_mask_d       = wr_mask_q;
    ifu_rsp_valid_d = 1'b0;
    lsu_rsp_valid_d = 1'b0;
    ifu_rsp_data_d  = ifu_rsp_data_q;
    lsu_rsp_data_d  = lsu_rsp_data_q;
`ifdef MEM_ARB_RR_EN
    last_d          = last_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          state_d         = ST_ISSUE;
          owner_d         = OWN_LSU;
          mem_req_valid_d = 1'b1;
          wr_en_d         = bus.i_lsu_req_wr_en;
          addr_d          = bus.i_lsu_req_addr;
          wr_data_d       = bus.i_lsu_req_wr_data;
          wr_mask_d       = bus.i_lsu_req_wr_mask;
`ifdef MEM_ARB_RR_EN
          last_d          = OWN_LSU;
`endif
        end else if (grant_ifu) begin
          // Fetches are reads: no write data or byte enables are driven.
          state_d         = ST_ISSUE;
          owner_d         = OWN_IFU;
          mem_req_valid_d = 1'b1;
          wr_en_d         = 1'b0;
          addr_d          = bus.i_ifu_req_addr;
          wr_data_d       = '0;
          wr_mask_d       = '0;
`ifdef MEM_ARB_RR_EN
          last_d          = OWN_IFU;
`endif
        end
      end

      ST_ISSUE: begin
        if (bus.i_mem_req_ready) begin
          state_d         = ST_WAIT;
          mem_req_valid_d = 1'b0;
        end
      end

      ST_WAIT: begin
        if (bus.i_mem_rsp_valid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rsp_data_d  = bus.i_mem_rsp_data;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rsp_data_d  = bus.i_mem_rsp_data;
          end
        end
      end

      default: begin
        state_d         = ST_IDLE;
        mem_req_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IFU;
      mem_req_valid_q <= 1'b0;
      wr_en_q         <= 1'b0;
      addr_q          <= '0;
      wr_data_q       <= '0;
      wr_mask_q       <= '0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      ifu_rsp_data_q  <= '0;
      lsu_rsp_data_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q          <= OWN_IFU;
`endif
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      mem_req_valid_q <= mem_req_valid_d;
      wr_en_q         <= wr_en_d;
      addr_q          <= addr_d;
      wr_data_q       <= wr_data_d;
      wr_mask_q       <= wr_mask_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      ifu_rsp_data_q  <= ifu_rsp_data_d;
      lsu_rsp_data_q  <= lsu_rsp_data_d;
`ifdef MEM_ARB_RR_EN
      last_q          <= last_d;
`endif
    end
  end

  assign bus.o_mem_req_valid   = mem_req_valid_q;
  assign bus.o_mem_req_wr_en   = wr_en_q;
  assign bus.o_mem_req_addr    = addr_q;
  assign bus.o_mem_req_wr_data = wr_data_q;
  assign bus.o_mem_req_wr_mask = wr_mask_q;

  assign bus.o_ifu_rsp_valid   = ifu_rsp_valid_q;
  assign bus.o_ifu_rsp_data    = ifu_rsp_data_q;
  assign bus.o_lsu_rsp_valid   = lsu_rsp_valid_q;
  assign bus.o_lsu_rsp_data    = lsu_rsp_data_q;
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width in bits.
REQ-003 i_sys_clk  in  1  single clock; all state on rising edge.
REQ-004 i_sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_ifu_req_valid  in  1  instruction-fetch read request.
REQ-006 o_ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-007 i_ifu_req_addr  in  ADDR_WIDTH  fetch address.
REQ-008 o_ifu_rsp_valid  out  1  one-cycle pulse: fetch data valid.
REQ-009 o_ifu_rsp_data  out  DATA_WIDTH  fetched instruction word.
REQ-010 i_lsu_req_valid  in  1  load/store request.
REQ-011 o_lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-012 i_lsu_req_wr_en  in  1  1 = store, 0 = load.
REQ-013 i_lsu_req_addr  in  ADDR_WIDTH  load/store address.
REQ-014 i_lsu_req_wr_data  in  DATA_WIDTH  store data.
REQ-015 i_lsu_req_wr_mask  in  DATA_WIDTH/8  store byte enables.
REQ-016 o_lsu_rsp_valid  out  1  one-cycle pulse: load data valid / store done.
REQ-017 o_lsu_rsp_data  out  DATA_WIDTH  load data (don't-care for stores).
REQ-018 o_mem_req_valid / i_mem_req_ready  out/in  1/1  shared memory port request handshake.
REQ-019 o_mem_req_wr_en, o_mem_req_addr, o_mem_req_wr_data, o_mem_req_wr_mask  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  latched request fields.
REQ-020 i_mem_rsp_valid / i_mem_rsp_data  in  1/DATA_WIDTH  memory response (reads and write acks).

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; at most one transaction outstanding.
REQ-022 IDLE: if any req_valid, winner's req_ready SHALL be 1 combinationally that cycle; winner fields and owner ID latched; next state ISSUE. Loser's ready SHALL be 0.
REQ-023 ISSUE: o_mem_req_valid=1 with latched fields held stable; on i_mem_req_ready=1 -> WAIT.
REQ-024 WAIT: on i_mem_rsp_valid=1, register i_mem_rsp_data into owner's rsp_data and pulse owner's rsp_valid the next cycle; next state IDLE.
REQ-025 Minimum latency: accept at T, mem_req_valid at T+1, with ready at T+1 and rsp at T+2, owner rsp_valid at T+3; next grant no earlier than T+3.
REQ-026 i_mem_rsp_valid outside WAIT SHALL be ignored; req_ready SHALL be 0 outside IDLE.
REQ-027 rsp_data SHALL hold its value until that requester's next response.
REQ-028 Requesters SHALL hold valid and fields until ready; arbiter samples fields only on the accept cycle.

Reset
REQ-029 On i_sys_rst (asynchronous): state IDLE, all valid/ready outputs 0, latched fields, rsp_data and RR pointer 0.
REQ-030 Reset mid-transaction SHALL drop o_mem_req_valid immediately and discard any in-flight response; no rsp_valid pulse follows.

Configuration
REQ-031 With MEM_ARB_RR_EN defined: round-robin; 1-bit last-grant pointer, simultaneous requests granted to the requester not last granted; pointer updates on each accept.
REQ-032 Without MEM_ARB_RR_EN: fixed priority, LSU always wins on simultaneous requests; no pointer state.

Verification
REQ-033 IFU read 0x0000_0010, mem ready immediately, rsp 0x0000_0013 next cycle -> o_ifu_rsp_valid one pulse at T+3, data 0x0000_0013; o_lsu_rsp_valid stays 0.
REQ-034 LSU store addr 0x100, data 0xDEAD_BEEF, mask 0xF -> mem sees wr_en=1 with exact fields; ack -> o_lsu_rsp_valid one pulse.
REQ-035 Both valid every cycle for 4 grants -> RR: LSU,IFU,LSU,IFU (pointer reset 0 = IFU last); fixed: LSU x4, IFU starved.
REQ-036 i_mem_req_ready held 0 for 5 cycles in ISSUE -> mem_req fields stable, both req_ready 0, no responses.
REQ-037 Assert i_sys_rst during WAIT, then deliver i_mem_rsp_valid -> no rsp_valid pulse, state IDLE, new request accepted normally.
